regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 63 ++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter merging two writeback requesters onto one register-file write port
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);
    logic              r_last_grant;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_conflict_cnt;
    logic              w_grant_a;
    logic              w_grant_b;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    always_comb begin
        w_grant_a  = !rst && a_valid && (!b_valid || r_last_grant);
        w_grant_b  = !rst && b_valid && (!a_valid || !r_last_grant);
        w_sel_addr = w_grant_b ? b_addr : a_addr;
        w_sel_data = w_grant_b ? b_data : a_data;
    end
    assign a_ready      = w_grant_a;
    assign b_ready      = w_grant_b;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign conflict_cnt = r_conflict_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant   <= 1'b1;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            // address-0 writes still handshake but never reach the register file
            r_wr_en <= (w_grant_a || w_grant_b) && !(ZERO_PROTECT && w_sel_addr == '0);
            if (w_grant_a || w_grant_b) begin
                r_last_grant <= w_grant_b;
                r_wr_addr    <= w_sel_addr;
                r_wr_data    <= w_sel_data;
            end
            if (a_valid && b_valid && r_conflict_cnt != '1)
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end
endmodule
